// File: rtl/ram_fifo_ctrl_8x16.sv
// FIFO controller for an external dual-port RAM with a registered read port.
// Pointers, occupancy and sticky error flags live here; data storage is external.
module ram_fifo_ctrl_8x16 #(
  parameter int width    = 16,
  parameter int depth    = 8,
  parameter int addr_bus = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                push,
  input  logic [width-1:0]    push_data,
  input  logic                pop,
  output logic                pop_valid,
  output logic [width-1:0]    pop_data,
  output logic                full,
  output logic                empty,
  output logic [addr_bus:0]   count,
  output logic                overflow,
  output logic                underflow,
  output logic                ram_we,
  output logic [addr_bus-1:0] ram_wr_addr,
  output logic [width-1:0]    ram_d_in,
  output logic                ram_re,
  output logic [addr_bus-1:0] ram_rd_addr,
  input  logic [width-1:0]    ram_d_out
);

  localparam logic [addr_bus:0]   DepthC = (addr_bus + 1)'(depth);
  localparam logic [addr_bus-1:0] PtrOne = addr_bus'(1);
  localparam logic [addr_bus:0]   CntOne = (addr_bus + 1)'(1);

  logic [addr_bus-1:0] wr_ptr_q, wr_ptr_d;
  logic [addr_bus-1:0] rd_ptr_q, rd_ptr_d;
  logic [addr_bus:0]   count_q, count_d;
  logic                pop_valid_q, overflow_q, underflow_q;
  logic                push_ok, pop_ok;

  assign full  = (count_q == DepthC);
  assign empty = (count_q == '0);
  assign count = count_q;

  // Reset gates the strobes so nothing reaches the RAM during a reset cycle.
  assign push_ok = push & ~full  & ~rst;
  assign pop_ok  = pop  & ~empty & ~rst;

  assign ram_we      = push_ok;
  assign ram_wr_addr = wr_ptr_q;
  assign ram_d_in    = push_data;
  assign ram_re      = pop_ok;
  assign ram_rd_addr = rd_ptr_q;

  assign pop_valid = pop_valid_q;
  // Masked so stale RAM output never leaks outside a valid cycle.
  assign pop_data  = pop_valid_q ? ram_d_out : '0;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

  always_comb begin
    wr_ptr_d = push_ok ? wr_ptr_q + PtrOne : wr_ptr_q;
    rd_ptr_d = pop_ok  ? rd_ptr_q + PtrOne : rd_ptr_q;
    count_d  = count_q;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CntOne;
      2'b01:   count_d = count_q - CntOne;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      pop_valid_q <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      pop_valid_q <= pop_ok;
      overflow_q  <= overflow_q  | (push & full);
      underflow_q <= underflow_q | (pop & empty);
    end
  end

endmodule

// File: tb/tb_ram_fifo_ctrl_8x16.sv
// Directed bench for ram_fifo_ctrl_8x16 with a behavioural registered-read RAM
// and a scoreboard queue consumed by an independent pop_valid monitor.
module tb_ram_fifo_ctrl_8x16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        push = 1'b0;
  logic [15:0] push_data = '0;
  logic        pop = 1'b0;
  logic        pop_valid;
  logic [15:0] pop_data;
  logic        full, empty;
  logic [3:0]  count;
  logic        overflow, underflow;
  logic        ram_we, ram_re;
  logic [2:0]  ram_wr_addr, ram_rd_addr;
  logic [15:0] ram_d_in;
  logic [15:0] ram_d_out = '0;

  logic [15:0] mem [8];
  logic [15:0] exp_q[$];
  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  ram_fifo_ctrl_8x16 dut (
    .clk(clk), .rst(rst), .push(push), .push_data(push_data), .pop(pop),
    .pop_valid(pop_valid), .pop_data(pop_data), .full(full), .empty(empty),
    .count(count), .overflow(overflow), .underflow(underflow),
    .ram_we(ram_we), .ram_wr_addr(ram_wr_addr), .ram_d_in(ram_d_in),
    .ram_re(ram_re), .ram_rd_addr(ram_rd_addr), .ram_d_out(ram_d_out)
  );

  initial for (int i = 0; i < 8; i++) mem[i] = 16'hDEAD;

  always @(posedge clk) begin
    if (ram_we) mem[ram_wr_addr] <= ram_d_in;
    if (ram_re) ram_d_out <= mem[ram_rd_addr];
  end

  // Expected words are queued right after the accepting edge, so each one must
  // be matched by pop_valid at the very next falling edge.
  always @(negedge clk) begin
    if (pop_valid || exp_q.size() > 0) begin
      vectors++;
      if (!pop_valid) begin
        errors++;
        $display("FAIL pop_valid_missing: pop_valid=0 required=1 (expected data %h)", exp_q.pop_front());
      end else if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL pop_valid_spurious: pop_valid=1 data=%h required pop_valid=0", pop_data);
      end else begin
        logic [15:0] e;
        e = exp_q.pop_front();
        if (pop_data !== e) begin
          errors++;
          $display("FAIL pop_data: got %h required %h", pop_data, e);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  // One clock: drive inputs, check combinational RAM strobes, then queue data.
  task automatic step(input logic p, input logic [15:0] d, input logic q, input logic r,
                      input logic exp_we, input logic exp_re,
                      input logic [2:0] exp_wa, input logic [2:0] exp_ra,
                      input logic exp_pv, input logic [15:0] exp_data);
    @(negedge clk);
    push = p; push_data = d; pop = q; rst = r;
    #1;
    chk("ram_we", 32'(ram_we), 32'(exp_we));
    chk("ram_re", 32'(ram_re), 32'(exp_re));
    chk("ram_wr_addr", 32'(ram_wr_addr), 32'(exp_wa));
    chk("ram_rd_addr", 32'(ram_rd_addr), 32'(exp_ra));
    if (exp_we) chk("ram_d_in", 32'(ram_d_in), 32'(d));
    @(posedge clk);
    #1;
    if (exp_pv) exp_q.push_back(exp_data);
    push = 1'b0; pop = 1'b0; rst = 1'b0;
  endtask

  task automatic chk_state(input string tag, input logic [3:0] c, input logic f, input logic e,
                           input logic ov, input logic un);
    chk({tag, ".count"}, 32'(count), 32'(c));
    chk({tag, ".full"}, 32'(full), 32'(f));
    chk({tag, ".empty"}, 32'(empty), 32'(e));
    chk({tag, ".overflow"}, 32'(overflow), 32'(ov));
    chk({tag, ".underflow"}, 32'(underflow), 32'(un));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset dominates a concurrent push and pop.
    step(1, 16'h1234, 1, 1, 0, 0, 3'd0, 3'd0, 0, '0);
    chk_state("reset", 4'd0, 0, 1, 0, 0);
    chk("reset.pop_valid", 32'(pop_valid), 32'd0);

    // Pop while empty.
    step(0, '0, 1, 0, 0, 0, 3'd0, 3'd0, 0, '0);
    chk_state("underflow", 4'd0, 0, 1, 0, 1);
    step(0, '0, 0, 1, 0, 0, 3'd0, 3'd0, 0, '0);
    chk_state("unf_clear", 4'd0, 0, 1, 0, 0);

    // Three pushes then three back-to-back pops.
    step(1, 16'h1111, 0, 0, 1, 0, 3'd0, 3'd0, 0, '0);
    step(1, 16'h2222, 0, 0, 1, 0, 3'd1, 3'd0, 0, '0);
    step(1, 16'h3333, 0, 0, 1, 0, 3'd2, 3'd0, 0, '0);
    chk_state("three_in", 4'd3, 0, 0, 0, 0);
    step(0, '0, 1, 0, 0, 1, 3'd3, 3'd0, 1, 16'h1111);
    step(0, '0, 1, 0, 0, 1, 3'd3, 3'd1, 1, 16'h2222);
    step(0, '0, 1, 0, 0, 1, 3'd3, 3'd2, 1, 16'h3333);
    step(0, '0, 0, 0, 0, 0, 3'd3, 3'd3, 0, '0);
    chk_state("three_out", 4'd0, 0, 1, 0, 0);

    // Fill, overflow, drain.
    step(0, '0, 0, 1, 0, 0, 3'd3, 3'd3, 0, '0);
    for (int i = 0; i < 8; i++)
      step(1, 16'hA000 + 16'(i), 0, 0, 1, 0, 3'(i), 3'd0, 0, '0);
    chk_state("filled", 4'd8, 1, 0, 0, 0);
    step(1, 16'hA008, 0, 0, 0, 0, 3'd0, 3'd0, 0, '0);
    chk_state("overflow", 4'd8, 1, 0, 1, 0);
    for (int i = 0; i < 8; i++)
      step(0, '0, 1, 0, 0, 1, 3'd0, 3'(i), 1, 16'hA000 + 16'(i));
    step(0, '0, 0, 0, 0, 0, 3'd0, 3'd0, 0, '0);
    chk_state("drained", 4'd0, 0, 1, 1, 0);

    // Steady state at count=4 with simultaneous push/pop across wrap.
    for (int i = 0; i < 4; i++)
      step(1, 16'hB000 + 16'(i), 0, 0, 1, 0, 3'(i), 3'd0, 0, '0);
    for (int i = 0; i < 10; i++)
      step(1, 16'hC000 + 16'(i), 1, 0, 1, 1, 3'(4 + i), 3'(i), 1,
           (i < 4) ? 16'hB000 + 16'(i) : 16'hC000 + 16'(i - 4));
    chk_state("steady", 4'd4, 0, 0, 1, 0);

    // Pop to count=3, pop again, then reset on the following edge.
    step(0, '0, 1, 0, 0, 1, 3'd6, 3'd2, 1, 16'hC006);
    chk_state("count3", 4'd3, 0, 0, 1, 0);
    step(0, '0, 1, 0, 0, 1, 3'd6, 3'd3, 1, 16'hC007);
    step(0, '0, 1, 1, 0, 0, 3'd6, 3'd4, 0, '0);
    chk_state("mid_reset", 4'd0, 0, 1, 0, 0);
    chk("mid_reset.pop_valid", 32'(pop_valid), 32'd0);
    step(1, 16'h5A5A, 0, 0, 1, 0, 3'd0, 3'd0, 0, '0);
    step(0, '0, 1, 0, 0, 1, 3'd1, 3'd0, 1, 16'h5A5A);
    step(0, '0, 0, 0, 0, 0, 3'd1, 3'd1, 0, '0);
    chk_state("final", 4'd0, 0, 1, 0, 0);

    repeat (2) @(negedge clk);
    #1;
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/ram_fifo_ctrl_8x16.md
RAM_FIFO_CTRL_8X16 -- requirements
Module: ram_fifo_ctrl_8x16

Interface
REQ-001 The block SHALL have parameter width, default 16, meaning data word width in bits.
REQ-002 The block SHALL have parameter depth, default 8, meaning number of RAM entries.
REQ-003 The block SHALL have parameter addr_bus, default 3, meaning RAM address width, with depth = 2^addr_bus.
REQ-004 The block SHALL have a single clock and a synchronous, active-high reset, described by REQ-005 and REQ-006.
REQ-005 Port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-006 Port rst, input, 1: synchronous, active-high reset.
REQ-007 Port push, input, 1: producer requests a write of push_data.
REQ-008 Port push_data, input, width: word to enqueue.
REQ-009 Port pop, input, 1: consumer requests the oldest word.
REQ-010 Port pop_valid, output, 1: pop_data holds a dequeued word this cycle.
REQ-011 Port pop_data, output, width: dequeued word.
REQ-012 Port full, output, 1: count == depth.
REQ-013 Port empty, output, 1: count == 0.
REQ-014 Port count, output, addr_bus+1: occupancy, range 0..depth.
REQ-015 Port overflow, output, 1: sticky flag for a push attempted while full.
REQ-016 Port underflow, output, 1: sticky flag for a pop attempted while empty.
REQ-017 Port ram_we, output, 1: write enable to the attached dual-port RAM.
REQ-018 Port ram_wr_addr, output, addr_bus: RAM write address.
REQ-019 Port ram_d_in, output, width: RAM write data.
REQ-020 Port ram_re, output, 1: read enable to the RAM.
REQ-021 Port ram_rd_addr, output, addr_bus: RAM read address.
REQ-022 Port ram_d_out, input, width: RAM read data, registered by the RAM, valid one cycle after ram_re.

Function
REQ-023 The block SHALL accept a push when push=1 and full=0. It SHALL accept a pop when pop=1 and empty=0. Flags SHALL be evaluated on pre-edge state.
REQ-024 Simultaneous push and pop SHALL both be accepted when each is individually permitted, with count unchanged. A push while full SHALL be rejected even if pop=1 in the same cycle.
REQ-025 On an accepted push, the block SHALL drive, combinationally in the same cycle: ram_we=1, ram_wr_addr=wr_ptr, ram_d_in=push_data. wr_ptr SHALL then increment modulo depth (7 -> 0).
REQ-026 On an accepted pop, the block SHALL drive, combinationally: ram_re=1, ram_rd_addr=rd_ptr. rd_ptr SHALL then increment modulo depth.
REQ-027 ram_we and ram_re SHALL be 0 in any cycle without an accepted push or pop respectively. ram_wr_addr SHALL always equal wr_ptr and ram_rd_addr SHALL always equal rd_ptr.
REQ-028 pop_valid SHALL be asserted exactly one cycle after an accepted pop, for one cycle per pop. pop_data SHALL equal ram_d_out during that cycle, giving a pop-to-data latency of 1 clock; back-to-back pops SHALL produce back-to-back pop_valid.
REQ-029 count SHALL update as follows: +1 on push-only, -1 on pop-only, unchanged on both or neither. full and empty SHALL derive from the registered count.
REQ-030 overflow SHALL set on a cycle with push=1 and full=1, and underflow SHALL set on a cycle with pop=1 and empty=1. Both SHALL remain set until rst, and a rejected request SHALL change no pointer, count or RAM strobe.
REQ-031 The block SHALL never issue ram_re to an entry not yet written, so read-during-write to the same address SHALL not occur.
REQ-032 Data SHALL emerge in strict FIFO order across pointer wrap-around.

Reset
REQ-033 While rst=1 at a clock edge, the block SHALL set wr_ptr=0, rd_ptr=0, count=0, empty=1, full=0, pop_valid=0, overflow=0, underflow=0, and SHALL drive ram_we=0 and ram_re=0 during that cycle regardless of push or pop.
REQ-034 rst SHALL dominate a concurrent push or pop, and a pop accepted in the cycle before rst SHALL produce no pop_valid after reset.
REQ-035 RAM contents SHALL not be cleared by reset, and stale contents SHALL never appear on pop_data.

Verification
REQ-036 Reset then push 0x1111, 0x2222, 0x3333 followed by 3 pops -> pop_valid on 3 consecutive cycles, each 1 clock after its pop, with data 0x1111, 0x2222, 0x3333; empty=1 and count=0 at end.
REQ-037 Push 8 words 0xA000..0xA007 -> full=1, count=8. A 9th push -> ram_we=0, overflow=1, count=8. Then 8 pops -> data 0xA000..0xA007 in order.
REQ-038 Pop while empty after reset -> ram_re=0, no pop_valid, underflow=1, pointers stay 0.
REQ-039 With count=4, push and pop in the same cycle for 10 cycles -> count stays 4, both pointers wrap past 7, and output order is preserved.
REQ-040 With count=3 and a pop issued, assert rst on the next edge -> pop_valid=0, count=0, empty=1, flags cleared. A subsequent push/pop of 0x5A5A -> pop_data=0x5A5A.
